bit_places_to_values_decoder: RTL and testbench

// - Reader of the activation bit-places FIFO; rebuilds 8-bit activation values from the bit-place token stream.
// - Token = one set-bit position, emitted MSB first, plus framing flags: LAST closes a value, ZERO encodes an all-zero value.
// - Writes each rebuilt value into a downstream values FIFO, giving loop-back checking of the value-to-bit converter path.

---
 rtl/bit_places_to_values_decoder.sv | 127 ++++++++++++
 tb/tb_bit_places_to_values_decoder.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bit_places_to_values_decoder.sv
// bit_places_to_values_decoder
// Reads the activation bit-places token FIFO and rebuilds 8-bit activation
// values. Each token names one set bit, MSB first. LAST closes a value and
// ZERO stands for an all-zero value. Each rebuilt value is written into the
// downstream values FIFO, which gives a loop-back check of the
// value-to-bit-places converter.
//
// Optional build macro: BIT_PLACES_DECODER_CHECK_EN
//   Defined   - sticky ErrorFlag reports token ordering and framing violations.
//   Undefined - ErrorFlag is tied low and no checking logic is built.
module bit_places_to_values_decoder #(
    parameter int VALUE_W = 8,
    parameter int PLACE_W = 3,   // must be clog2(VALUE_W)
    parameter int COUNT_W = 16
) (
    input  logic               CLK,
    input  logic               RSTN,
    input  logic               ActBitPlacesFIFOReadReady,
    output logic               ActBitPlacesFIFOReadEnable,
    input  logic [PLACE_W+1:0] ActBitPlacesFIFOReadDataOut,
    input  logic               ActValuesFIFOWriteReady,
    output logic               ActValuesFIFOWriteEnable,
    output logic [VALUE_W-1:0] ActValuesFIFOWriteDataIn,
    output logic [COUNT_W-1:0] ValuesOutCount,
    output logic               ErrorFlag
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    state_t             state;
    logic [VALUE_W-1:0] acc;
    // Set while the next token to be read opens a new value
    logic               first;

    logic               tokLast;
    logic               tokZero;
    logic [PLACE_W-1:0] tokPlace;
    logic [VALUE_W-1:0] placeMask;

    assign tokLast   = ActBitPlacesFIFOReadDataOut[PLACE_W+1];
    assign tokZero   = ActBitPlacesFIFOReadDataOut[PLACE_W];
    assign tokPlace  = ActBitPlacesFIFOReadDataOut[PLACE_W-1:0];
    assign placeMask = VALUE_W'(1) << tokPlace;

    // Token/value sequencer: read a token, OR its place into acc, and on
    // LAST write the finished value once the values FIFO has room.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state                      <= S_IDLE;
            ActBitPlacesFIFOReadEnable <= 1'b0;
            ActValuesFIFOWriteEnable   <= 1'b0;
            ActValuesFIFOWriteDataIn   <= '0;
            acc                        <= '0;
            ValuesOutCount             <= '0;
            first                      <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    ActValuesFIFOWriteEnable <= 1'b0;
                    if (ActBitPlacesFIFOReadReady) begin
                        ActBitPlacesFIFOReadEnable <= 1'b1;
                        state                      <= S_READ;
                    end else begin
                        ActBitPlacesFIFOReadEnable <= 1'b0;
                    end
                end
                S_READ: begin
                    ActBitPlacesFIFOReadEnable <= 1'b0;
                    ActValuesFIFOWriteEnable   <= 1'b0;
                    // ZERO tokens carry no place; OR makes repeated places harmless
                    if (!tokZero) begin
                        acc <= acc | placeMask;
                    end
                    first <= tokLast;
                    state <= tokLast ? S_WRITE : S_IDLE;
                end
                S_WRITE: begin
                    ActBitPlacesFIFOReadEnable <= 1'b0;
                    if (ActValuesFIFOWriteReady) begin
                        ActValuesFIFOWriteEnable <= 1'b1;
                        ActValuesFIFOWriteDataIn <= acc;
                        acc                      <= '0;
                        ValuesOutCount           <= ValuesOutCount + COUNT_W'(1);
                        state                    <= S_IDLE;
                    end else begin
                        ActValuesFIFOWriteEnable <= 1'b0;
                    end
                end
                default: begin
                    ActBitPlacesFIFOReadEnable <= 1'b0;
                    ActValuesFIFOWriteEnable   <= 1'b0;
                    state                      <= S_IDLE;
                end
            endcase
        end
    end

`ifdef BIT_PLACES_DECODER_CHECK_EN
    logic [PLACE_W-1:0] prevPlace;

    // Protocol checker: places inside a value must strictly decrease, and a
    // ZERO token must be the only token of its value. The data path is not
    // affected; the flag only records that a violation was seen.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            ErrorFlag <= 1'b0;
            prevPlace <= '0;
        end else if (state == S_READ) begin
            if (!tokZero) begin
                if (!first && (tokPlace >= prevPlace)) begin
                    ErrorFlag <= 1'b1;
                end
                prevPlace <= tokPlace;
            end else if (!tokLast || !first) begin
                ErrorFlag <= 1'b1;
            end
        end
    end
`else
    assign ErrorFlag = 1'b0;
`endif

endmodule

// File: tb/tb_bit_places_to_values_decoder.sv
// Bench for bit_places_to_values_decoder: a queue-based token FIFO model feeds
// the decoder; every written value is compared with the value the tokens were
// generated from. A second instance with a 4-bit counter covers counter wrap.
module tb_bit_places_to_values_decoder;

    localparam int VALUE_W = 8;
    localparam int PLACE_W = 3;
    localparam int COUNT_W = 16;
`ifdef BIT_PLACES_DECODER_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic               CLK = 1'b0;
    logic               RSTN = 1'b0;
    logic               rdReady = 1'b0;
    logic               rdEn;
    logic [PLACE_W+1:0] rdData = '0;
    logic               wrReady = 1'b0;
    logic               wrEn;
    logic [VALUE_W-1:0] wrData;
    logic [COUNT_W-1:0] count;
    logic               err;

    // wrap instance: endless stream of single-token zero values
    logic               wrapRdReady = 1'b1;
    logic               wrapRdEn;
    logic [PLACE_W+1:0] wrapRdData = 5'b11000;
    logic               wrapWrReady = 1'b1;
    logic               wrapWrEn;
    logic [VALUE_W-1:0] wrapWrData;
    logic [3:0]         wrapCount;
    logic               wrapErr;

    always #5 CLK = ~CLK;

    bit_places_to_values_decoder #(.VALUE_W(VALUE_W), .PLACE_W(PLACE_W), .COUNT_W(COUNT_W)) dut (
        .CLK(CLK), .RSTN(RSTN),
        .ActBitPlacesFIFOReadReady(rdReady), .ActBitPlacesFIFOReadEnable(rdEn),
        .ActBitPlacesFIFOReadDataOut(rdData),
        .ActValuesFIFOWriteReady(wrReady), .ActValuesFIFOWriteEnable(wrEn),
        .ActValuesFIFOWriteDataIn(wrData), .ValuesOutCount(count), .ErrorFlag(err)
    );

    bit_places_to_values_decoder #(.VALUE_W(VALUE_W), .PLACE_W(PLACE_W), .COUNT_W(4)) wrapDut (
        .CLK(CLK), .RSTN(RSTN),
        .ActBitPlacesFIFOReadReady(wrapRdReady), .ActBitPlacesFIFOReadEnable(wrapRdEn),
        .ActBitPlacesFIFOReadDataOut(wrapRdData),
        .ActValuesFIFOWriteReady(wrapWrReady), .ActValuesFIFOWriteEnable(wrapWrEn),
        .ActValuesFIFOWriteDataIn(wrapWrData), .ValuesOutCount(wrapCount), .ErrorFlag(wrapErr)
    );

    int nTests = 0;
    int nFail  = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // token FIFO and expectation model
    logic [PLACE_W+1:0] tokQ[$];
    logic [VALUE_W-1:0] expQ[$];
    logic               expErrQ[$];
    bit  popPending = 0;
    bit  rdGate = 1, wrGate = 1, randomMode = 0;
    bit  prevRdReady = 0, prevWrReady = 0, prevRdEn = 0, prevWrEn = 0;
    int  cyc = 0, nWr = 0, wrapN = 0, lastRdCyc = 0, lastWrCyc = 0;
    logic [VALUE_W-1:0] lastWrData = '0;
    // protocol-rule model state
    bit  mFirst = 1, mErr = 0;
    int  mPrev = 0;

    task automatic pushTok(input bit last, input bit zero, input int place);
        tokQ.push_back({last, zero, PLACE_W'(place)});
        if (zero) begin
            if (!last || !mFirst) mErr = 1;
        end else begin
            if (!mFirst && place >= mPrev) mErr = 1;
            mPrev = place;
        end
        mFirst = last;
    endtask

    task automatic endValue(input logic [VALUE_W-1:0] v);
        expQ.push_back(v);
        expErrQ.push_back(CHK ? mErr : 1'b0);
    endtask

    // Emit the tokens for value v MSB first; optionally repeat one place.
    task automatic pushValue(input logic [VALUE_W-1:0] v, input bit dup);
        logic [VALUE_W-1:0] rest;
        if (v == 0) begin
            pushTok(1, 1, 0);
        end else begin
            rest = v;
            for (int b = VALUE_W - 1; b >= 0; b--) begin
                if (v[b]) begin
                    rest[b] = 1'b0;
                    pushTok(rest == 0, 0, b);
                    if (dup && rest != 0) begin
                        pushTok(0, 0, b);
                        dup = 0;
                    end
                end
            end
        end
        endValue(v);
    endtask

    // FIFO model, write-side scoreboard and per-cycle protocol checks
    always @(negedge CLK) begin
        bit rg, wg;
        cyc++;
        if (!RSTN) begin
            popPending = 0; nWr = 0; wrapN = 0;
            prevRdEn = 0; prevWrEn = 0;
        end else begin
            if (rdEn) begin
                check("rdReadyBefore", prevRdReady, 1);
                check("rdOnePulse", prevRdEn, 0);
            end
            if (popPending) begin
                void'(tokQ.pop_front());
                popPending = 0;
            end
            if (rdEn && tokQ.size() > 0) begin
                popPending = 1;
                if (tokQ[0][PLACE_W+1]) lastRdCyc = cyc;
            end
            if (wrEn) begin
                nWr++;
                lastWrData = wrData;
                lastWrCyc = cyc;
                check("wrReadyBefore", prevWrReady, 1);
                check("wrOnePulse", prevWrEn, 0);
                check("wrQueued", 32'(expQ.size() > 0), 1);
                if (expQ.size() > 0) begin
                    check("wrData", wrData, expQ.pop_front());
                    check("wrErrFlag", err, expErrQ.pop_front());
                end
                check("wrCount", count, nWr & 32'hFFFF);
            end
            if (wrapWrEn) begin
                wrapN++;
                check("wrapCount", wrapCount, wrapN % 16);
            end
            prevRdEn = rdEn;
            prevWrEn = wrEn;
        end
        if (randomMode) begin
            rg = $urandom_range(0, 3) != 0;
            wg = $urandom_range(0, 3) != 0;
        end else begin
            rg = rdGate;
            wg = wrGate;
        end
        rdReady = (tokQ.size() > 32'(popPending)) && rg;
        rdData  = (tokQ.size() > 0) ? tokQ[0] : '0;
        wrReady = wg;
        prevRdReady = rdReady;
        prevWrReady = wrReady;
    end

    task automatic waitWrites(input string tag, input int n, input int budget);
        int k = 0;
        while (nWr < n && k < budget) begin
            @(posedge CLK);
            k++;
        end
        #2;
        check(tag, nWr, n);
    endtask

    task automatic waitTokens(input string tag, input int left);
        int k = 0;
        while ((tokQ.size() > left || popPending) && k < 200) begin
            @(posedge CLK);
            k++;
        end
        #2;
        check(tag, tokQ.size(), left);
    endtask

    task automatic doReset();
        @(posedge CLK); #2;
        RSTN = 0;
        mFirst = 1; mErr = 0; mPrev = 0;
        expQ.delete(); expErrQ.delete();
        @(posedge CLK); #2;
        RSTN = 1;
    endtask

    initial begin
        int base;
        logic [VALUE_W-1:0] v;

        // reset state
        repeat (3) @(posedge CLK);
        #2;
        check("rstRdEn", rdEn, 0);
        check("rstWrEn", wrEn, 0);
        check("rstWrData", wrData, 0);
        check("rstCount", count, 0);
        check("rstErr", err, 0);
        RSTN = 1;

        // single ZERO|LAST token -> 0x00
        pushTok(1, 1, 0); endValue(8'h00);
        waitWrites("t1Writes", 1, 50);
        check("t1Data", lastWrData, 8'h00);
        check("t1Count", count, 1);
        check("t1Err", err, 0);

        // 7, 2, 0(LAST) -> 0x85, write 2 cycles after last read
        pushTok(0, 0, 7); pushTok(0, 0, 2); pushTok(1, 0, 0); endValue(8'h85);
        waitWrites("t2Writes", 2, 50);
        check("t2Data", lastWrData, 8'h85);
        check("t2Latency", lastWrCyc - lastRdCyc, 2);

        // 0x90 with values FIFO full for 5 cycles; next token waits
        wrGate = 0;
        pushTok(0, 0, 7); pushTok(1, 0, 4); endValue(8'h90);
        pushTok(1, 1, 0); endValue(8'h00);
        waitTokens("t3Drain", 1);
        repeat (5) begin
            @(posedge CLK); #2;
            check("t3NoWr", wrEn, 0);
            check("t3NoRd", rdEn, 0);
        end
        check("t3Stalled", nWr, 2);
        wrGate = 1;
        waitWrites("t3Writes", 3, 50);
        check("t3Data", lastWrData, 8'h90);
        waitWrites("t3Writes2", 4, 50);

        // place 4, token FIFO empty for 10 cycles, place 1(LAST) -> 0x12
        pushTok(0, 0, 4);
        waitTokens("t4Drain", 0);
        rdGate = 0;
        pushTok(1, 0, 1); endValue(8'h12);
        repeat (10) begin
            @(posedge CLK); #2;
            check("t4NoRd", rdEn, 0);
        end
        rdGate = 1;
        waitWrites("t4Writes", 5, 50);
        check("t4Data", lastWrData, 8'h12);

        // randomized values with random back-pressure on both FIFOs
        randomMode = 1;
        base = nWr;
        for (int i = 0; i < 60; i++) begin
            v = VALUE_W'($urandom_range(0, 255));
            pushValue(v, $urandom_range(0, 7) == 0);
        end
        waitWrites("rndWrites", base + 60, 20000);
        randomMode = 0;

        // out-of-order places 2 then 5(LAST), then a clean value
        pushTok(0, 0, 2); pushTok(1, 0, 5); endValue(8'h24);
        waitWrites("t5Writes", base + 61, 50);
        check("t5Data", lastWrData, 8'h24);
        check("t5Err", err, CHK);
        pushValue(8'h01, 0);
        waitWrites("t5Writes2", base + 62, 50);
        check("t5ErrSticky", err, CHK);

        // reset mid-value discards the partial place 6
        pushTok(0, 0, 6);
        waitTokens("t6Drain", 0);
        doReset();
        check("t6Count0", count, 0);
        check("t6Err0", err, 0);
        pushTok(1, 0, 3); endValue(8'h08);
        waitWrites("t6Writes", 1, 50);
        check("t6Data", lastWrData, 8'h08);
        check("t6Count", count, 1);

        // let the 4-bit counter instance wrap at least once
        while (wrapN < 20 && cyc < 5000) @(posedge CLK);
        #2;
        check("wrapSeen", 32'(wrapN >= 20), 1);
        check("expDrained", expQ.size(), 0);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
